tophat_residual: RTL and testbench

- Downstream companion of the close stage. It taps the raw sample stream, forwards it to the close filter, and buffers each raw sample in a delay FIFO.
- When the matching filtered sample returns, it outputs the saturated residual: black top-hat = close(X) − X, or the reversed sign.
- The result is a streaming residual for peak/valley detection. It sits between the front-end sample source and the detector.

---
 rtl/morph_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/tophat_residual.sv | 92 +++++++++
 tb/tb_tophat_residual.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
// Shared types, mode constants and saturating arithmetic for the morphology stream blocks.
package morph_pkg;

   localparam int unsigned SAMPLE_WIDTH = 16;
   localparam int unsigned MAX_WIDTH    = 32;
   localparam int unsigned EXT_WIDTH    = MAX_WIDTH + 1;

   localparam int unsigned TOPHAT_BLACK = 0;
   localparam int unsigned TOPHAT_WHITE = 1;

   typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
   typedef logic signed [MAX_WIDTH-1:0]    wide_t;

   // a - b computed one bit wider than the operands, then clamped to a signed w-bit range
   function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int unsigned w);
      logic signed [EXT_WIDTH-1:0] d;
      logic signed [EXT_WIDTH-1:0] hi;
      logic signed [EXT_WIDTH-1:0] lo;
      d  = EXT_WIDTH'(a) - EXT_WIDTH'(b);
      hi = (EXT_WIDTH'(1) <<< (w - 1)) - EXT_WIDTH'(1);
      lo = -(EXT_WIDTH'(1) <<< (w - 1));
      if (d > hi) begin
         return wide_t'(hi);
      end else if (d < lo) begin
         return wide_t'(lo);
      end
      return wide_t'(d);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and occupancy count; no push-to-pop bypass.
module sync_fifo #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [DATA_WIDTH-1:0]        wdata,
   input  logic                         pop,
   output logic [DATA_WIDTH-1:0]        rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]     wr_ptr;
   logic [ADDR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]      count_nxt;
   logic                  do_push_c;
   logic                  do_pop_c;

   assign do_push_c = push & ~full;
   assign do_pop_c  = pop & ~empty;
   assign rdata     = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({do_push_c, do_pop_c})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   // Storage is not reset; only pointers and flags define validity.
   always_ff @(posedge clk) begin
      if (do_push_c) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push_c) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (do_pop_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
         count <= count_nxt;
         full  <= (count_nxt == CNT_W'(DEPTH));
         empty <= (count_nxt == CNT_W'(0));
      end
   end

endmodule

// File: rtl/tophat_residual.sv
// Top-hat residual: forwards raw samples to the close filter, delays them in a FIFO and
// emits the saturated difference against the returning filtered stream.
module tophat_residual
   import morph_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 256,
   parameter int unsigned MODE       = TOPHAT_BLACK
) (
   input  logic                                 clk,
   input  logic                                 areset_n,
   input  logic signed [DATA_WIDTH-1:0]         axis_in_tdata,
   input  logic                                 axis_in_tvalid,
   output logic                                 axis_in_tready,
   output logic signed [DATA_WIDTH-1:0]         axis_fwd_tdata,
   output logic                                 axis_fwd_tvalid,
   input  logic                                 axis_fwd_tready,
   input  logic signed [DATA_WIDTH-1:0]         axis_filt_tdata,
   input  logic                                 axis_filt_tvalid,
   output logic                                 axis_filt_tready,
   output logic signed [DATA_WIDTH-1:0]         axis_out_tdata,
   output logic                                 axis_out_tvalid,
   input  logic                                 axis_out_tready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fill_level,
   output logic                                 err_underflow
);

   logic                         full;
   logic                         empty;
   logic                         push_c;
   logic                         pop_c;
   logic                         out_free_c;
   logic [DATA_WIDTH-1:0]        fifo_rdata;
   logic signed [DATA_WIDTH-1:0] head;
   wide_t                        op_a;
   wide_t                        op_b;

   // Forward path is pure wiring so the filter and the FIFO accept the same samples.
   assign axis_fwd_tdata  = axis_in_tdata;
   assign axis_fwd_tvalid = axis_in_tvalid & ~full;
   assign axis_in_tready  = axis_fwd_tready & ~full;
   assign push_c          = axis_in_tvalid & axis_in_tready;

   assign out_free_c       = ~axis_out_tvalid | axis_out_tready;
   assign axis_filt_tready = out_free_c & ~empty;
   assign pop_c            = axis_filt_tvalid & axis_filt_tready;
   assign head             = fifo_rdata;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (areset_n),
      .push  (push_c),
      .wdata (axis_in_tdata),
      .pop   (pop_c),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty),
      .count (fill_level)
   );

   always_comb begin
      op_a = wide_t'(axis_filt_tdata);
      op_b = wide_t'(head);
      if (MODE == TOPHAT_WHITE) begin
         op_a = wide_t'(head);
         op_b = wide_t'(axis_filt_tdata);
      end
   end

   // Output register only loads on the filt handshake, which already implies it is free.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         axis_out_tdata  <= '0;
         axis_out_tvalid <= 1'b0;
         err_underflow   <= 1'b0;
      end else begin
         if (pop_c) begin
            axis_out_tdata  <= DATA_WIDTH'(sat_sub(op_a, op_b, DATA_WIDTH));
            axis_out_tvalid <= 1'b1;
         end else if (axis_out_tready) begin
            axis_out_tvalid <= 1'b0;
         end
         if (axis_filt_tvalid & empty) begin
            err_underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tophat_residual.sv
// Scoreboard bench for tophat_residual: raw/filt pairing, saturation, full, backpressure,
// underflow and mid-stream reset, plus a reversed-sign instance.
module tb_tophat_residual;

   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic                 clk = 1'b0;
   logic                 rst_n;

   logic signed [DW-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] fwd_data;
   logic                 fwd_valid;
   logic                 fwd_ready;
   logic signed [DW-1:0] filt_data;
   logic                 filt_valid;
   logic                 filt_ready;
   logic signed [DW-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [CW-1:0]        fill;
   logic                 err;

   logic signed [DW-1:0] b_in_data;
   logic                 b_in_valid;
   logic                 b_in_ready;
   logic signed [DW-1:0] b_fwd_data;
   logic                 b_fwd_valid;
   logic signed [DW-1:0] b_filt_data;
   logic                 b_filt_valid;
   logic                 b_filt_ready;
   logic signed [DW-1:0] b_out_data;
   logic                 b_out_valid;
   logic [CW-1:0]        b_fill;
   logic                 b_err;

   int raw_q[$];
   int exp_q[$];
   int obs_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   bit in_hs;
   bit filt_hs;
   bit out_hs;

   always #5 clk = ~clk;

   tophat_residual #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MODE(0)) dut (
      .clk(clk), .areset_n(rst_n),
      .axis_in_tdata(in_data), .axis_in_tvalid(in_valid), .axis_in_tready(in_ready),
      .axis_fwd_tdata(fwd_data), .axis_fwd_tvalid(fwd_valid), .axis_fwd_tready(fwd_ready),
      .axis_filt_tdata(filt_data), .axis_filt_tvalid(filt_valid), .axis_filt_tready(filt_ready),
      .axis_out_tdata(out_data), .axis_out_tvalid(out_valid), .axis_out_tready(out_ready),
      .fill_level(fill), .err_underflow(err)
   );

   tophat_residual #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MODE(1)) dut_w (
      .clk(clk), .areset_n(rst_n),
      .axis_in_tdata(b_in_data), .axis_in_tvalid(b_in_valid), .axis_in_tready(b_in_ready),
      .axis_fwd_tdata(b_fwd_data), .axis_fwd_tvalid(b_fwd_valid), .axis_fwd_tready(1'b1),
      .axis_filt_tdata(b_filt_data), .axis_filt_tvalid(b_filt_valid), .axis_filt_tready(b_filt_ready),
      .axis_out_tdata(b_out_data), .axis_out_tvalid(b_out_valid), .axis_out_tready(1'b1),
      .fill_level(b_fill), .err_underflow(b_err)
   );

   function automatic int model_res(int f, int r, bit mode);
      int d;
      d = mode ? (r - f) : (f - r);
      if (d > 32767) d = 32767;
      else if (d < -32768) d = -32768;
      return d;
   endfunction

   // Called right after the negedge drive; records this cycle's handshakes, returns at next negedge.
   task automatic step();
      int r;
      #1;
      in_hs   = in_valid & in_ready;
      filt_hs = filt_valid & filt_ready;
      out_hs  = out_valid & out_ready;
      if (in_hs) raw_q.push_back(int'(in_data));
      if (filt_hs && raw_q.size() > 0) begin
         r = raw_q.pop_front();
         exp_q.push_back(model_res(int'(filt_data), r, 1'b0));
      end
      if (out_hs) obs_q.push_back(int'(out_data));
      @(negedge clk);
   endtask

   task automatic clear_queues();
      raw_q.delete();
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (fill !== '0 || out_valid !== 1'b0 || out_data !== '0 || err !== 1'b0)
         $display("FAIL reset_state: fill=%0d valid=%0b data=%0d err=%0b required 0/0/0/0",
                  fill, out_valid, out_data, err);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1 || fwd_valid !== 1'b0)
         $display("FAIL reset_ready: in_ready=%0b fwd_valid=%0b required 1/0", in_ready, fwd_valid);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_identity();
      int idx = -100;
      bit dv[3] = '{0, 0, 0};
      int dd[3] = '{0, 0, 0};
      clear_queues();
      for (int cyc = 0; cyc < 600 && obs_q.size() < 201; cyc++) begin
         in_valid   = (idx <= 100);
         in_data    = DW'(idx);
         filt_valid = dv[2];
         filt_data  = DW'(dd[2]);
         step();
         if (in_hs) idx++;
         dv[2] = dv[1]; dd[2] = dd[1];
         dv[1] = dv[0]; dd[1] = dd[0];
         dv[0] = in_hs; dd[0] = int'(fwd_data);
      end
      in_valid   = 1'b0;
      filt_valid = 1'b0;
      n_checks++;
      if (obs_q.size() != 201 || exp_q.size() != 201)
         $display("FAIL identity_count: outputs=%0d expected_entries=%0d required 201", obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i] || obs_q[i] !== 0)
            $display("FAIL identity_out[%0d]: got %0d required %0d", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (err !== 1'b0) $display("FAIL identity_err: got %0b required 0", err);
      else n_pass++;
   endtask

   task automatic test_saturation();
      clear_queues();
      in_valid = 1'b1; in_data = -16'sd32768; step();
      in_data = 16'sd32767; step();
      in_valid = 1'b0;
      filt_valid = 1'b1; filt_data = 16'sd32767; step();
      filt_data = -16'sd32768; step();
      filt_valid = 1'b0;
      step(); step(); step();
      n_checks++;
      if (obs_q.size() != 2 || exp_q.size() != 2)
         $display("FAIL sat_count: got %0d outputs required 2", obs_q.size());
      else n_pass++;
      if (obs_q.size() == 2 && exp_q.size() == 2) begin
         n_checks++;
         if (obs_q[0] !== exp_q[0] || obs_q[0] !== 32767)
            $display("FAIL sat_pos: got %0d required 32767", obs_q[0]);
         else n_pass++;
         n_checks++;
         if (obs_q[1] !== exp_q[1] || obs_q[1] !== -32768)
            $display("FAIL sat_neg: got %0d required -32768", obs_q[1]);
         else n_pass++;
      end
   endtask

   task automatic test_full();
      int acc = 0;
      int k   = 0;
      clear_queues();
      filt_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(i);
         step();
         if (in_hs) acc++;
      end
      n_checks++;
      if (acc != 256) $display("FAIL full_accepted: got %0d required 256", acc);
      else n_pass++;
      n_checks++;
      if (fill !== 9'd256) $display("FAIL full_level: got %0d required 256", fill);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0 || fwd_valid !== 1'b0)
         $display("FAIL full_gating: in_ready=%0b fwd_valid=%0b required 0/0", in_ready, fwd_valid);
      else n_pass++;
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 1000 && obs_q.size() < 256; cyc++) begin
         filt_valid = (k < 256);
         filt_data  = DW'(k + 1);
         step();
         if (filt_hs) k++;
      end
      filt_valid = 1'b0;
      n_checks++;
      if (obs_q.size() != 256 || exp_q.size() != 256)
         $display("FAIL full_drain_count: got %0d outputs required 256", obs_q.size());
      else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i] || obs_q[i] !== 1)
            $display("FAIL full_drain[%0d]: got %0d required 1", i, obs_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (fill !== '0) $display("FAIL full_empty_level: got %0d required 0", fill);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      clear_queues();
      in_valid = 1'b1; in_data = 16'sd10; step();
      in_data = 16'sd20; step();
      in_valid = 1'b0;
      out_ready = 1'b0;
      filt_valid = 1'b1; filt_data = 16'sd52; step();
      filt_data = 16'sd25;
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 16'sd42 || filt_ready !== 1'b0)
            $display("FAIL bp_hold[%0d]: valid=%0b data=%0d filt_ready=%0b required 1/42/0",
                     i, out_valid, out_data, filt_ready);
         else n_pass++;
      end
      out_ready = 1'b1;
      step();
      filt_valid = 1'b0;
      step(); step(); step();
      n_checks++;
      if (obs_q.size() != 2 || exp_q.size() != 2)
         $display("FAIL bp_count: got %0d outputs required 2", obs_q.size());
      else n_pass++;
      if (obs_q.size() == 2 && exp_q.size() == 2) begin
         n_checks++;
         if (obs_q[0] !== 42 || obs_q[1] !== exp_q[1] || obs_q[1] !== 5)
            $display("FAIL bp_order: got %0d,%0d required 42,5", obs_q[0], obs_q[1]);
         else n_pass++;
      end
   endtask

   task automatic test_underflow();
      clear_queues();
      filt_valid = 1'b1; filt_data = 16'sd7;
      step();
      n_checks++;
      if (err !== 1'b1 || out_valid !== 1'b0 || filt_ready !== 1'b0)
         $display("FAIL underflow_set: err=%0b valid=%0b filt_ready=%0b required 1/0/0", err, out_valid, filt_ready);
      else n_pass++;
      step(); step(); step();
      filt_valid = 1'b0;
      step(); step();
      n_checks++;
      if (err !== 1'b1 || obs_q.size() != 0 || fill !== '0)
         $display("FAIL underflow_sticky: err=%0b outputs=%0d fill=%0d required 1/0/0", err, obs_q.size(), fill);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1; in_data = DW'(1000 + i); step();
      end
      in_valid = 1'b0;
      step();
      n_checks++;
      if (fill !== 9'd20) $display("FAIL mid_fill: got %0d required 20", fill);
      else n_pass++;
      out_ready = 1'b0;
      filt_valid = 1'b1; filt_data = 16'sd0; step();
      filt_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (fill !== '0 || out_valid !== 1'b0 || err !== 1'b0 || out_data !== '0)
         $display("FAIL mid_reset: fill=%0d valid=%0b err=%0b data=%0d required 0/0/0/0",
                  fill, out_valid, err, out_data);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      clear_queues();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = DW'(100 * (i + 1)); step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         filt_valid = 1'b1; filt_data = DW'(100 * (i + 1) + 5 + 2 * i); step();
      end
      filt_valid = 1'b0;
      step(); step();
      n_checks++;
      if (obs_q.size() != 3)
         $display("FAIL mid_fresh_count: got %0d outputs required 3", obs_q.size());
      else n_pass++;
      if (obs_q.size() == 3) begin
         n_checks++;
         if (obs_q[0] !== 5 || obs_q[1] !== 7 || obs_q[2] !== 9)
            $display("FAIL mid_fresh_vals: got %0d,%0d,%0d required 5,7,9", obs_q[0], obs_q[1], obs_q[2]);
         else n_pass++;
      end
   endtask

   task automatic test_mode_white();
      b_in_valid = 1'b1; b_in_data = 16'sd5;
      @(negedge clk);
      b_in_valid = 1'b0;
      b_filt_valid = 1'b1; b_filt_data = 16'sd2;
      #1;
      n_checks++;
      if (b_filt_ready !== 1'b1) $display("FAIL white_ready: got %0b required 1", b_filt_ready);
      else n_pass++;
      @(negedge clk);
      b_filt_valid = 1'b0;
      #1;
      n_checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== 16'sd3)
         $display("FAIL white_out: valid=%0b data=%0d required 1/3", b_out_valid, b_out_data);
      else n_pass++;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      in_data = '0; in_valid = 1'b0; fwd_ready = 1'b1;
      filt_data = '0; filt_valid = 1'b0; out_ready = 1'b1;
      b_in_data = '0; b_in_valid = 1'b0; b_filt_data = '0; b_filt_valid = 1'b0;
      test_reset();
      test_identity();
      test_saturation();
      test_full();
      test_backpressure();
      test_underflow();
      test_reset_mid();
      test_mode_white();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
